// File: rtl/chkmon_pkg.sv
// rtl/chkmon_pkg.sv - shared types and helpers for the checkpoint sequence monitor
package chkmon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } chkmon_state_e;

    localparam int CHKMON_MAX_CNT_W = 64;
    // Sliced down to CNT_W by users; CNT_W must not exceed CHKMON_MAX_CNT_W.
    localparam logic [CHKMON_MAX_CNT_W-1:0] CHKMON_CYC_ONES = '1;

    function automatic int chkmon_stage_w(input int num_stages);
        return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/chkmon_stage_timer.sv
// rtl/chkmon_stage_timer.sv - saturating per-stage cycle counter with deadline compare
module chkmon_stage_timer
    import chkmon_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_timeout,
    output logic [CNT_W-1:0] o_count,
    output logic             o_deadline
);

    localparam logic [CNT_W-1:0] CNT_ONES = CHKMON_CYC_ONES[CNT_W-1:0];

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_ONES)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    // A zero timeout disables the deadline entirely.
    assign o_deadline = (i_timeout != '0) && (r_count == (i_timeout - 1'b1));

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// rtl/checkpoint_seq_monitor.sv - ordered checkpoint-code watcher; option CHKMON_STABLE_FILTER_EN
module checkpoint_seq_monitor
    import chkmon_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int NUM_STAGES    = 4,
    parameter int CNT_W         = 24,
    parameter int STRICT        = 1,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic [WIDTH-1:0]                    check_i,
    input  logic [NUM_STAGES*WIDTH-1:0]         codes_i,
    input  logic [CNT_W-1:0]                    timeout_i,
    input  logic                                start_i,
    output logic                                busy_o,
    output logic                                pass_o,
    output logic                                fail_o,
    output logic                                timeout_o,
    output logic [chkmon_stage_w(NUM_STAGES)-1:0] stage_o,
    output logic [CNT_W-1:0]                    cycles_o
);

    localparam int                 STAGE_W    = chkmon_stage_w(NUM_STAGES);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    chkmon_state_e      r_state, w_state_nxt;
    logic [STAGE_W-1:0] r_stage, w_stage_nxt;
    logic [WIDTH-1:0]   w_code_cur;
    logic               w_eq_cur;
    logic               w_eq_later;
    logic               w_stable;
    logic               w_match;
    logic               w_early;
    logic               w_deadline;
    logic               w_tmr_clear;
    logic               w_tmr_inc;
    logic [CNT_W-1:0]   w_cycles;

    // Code mux for the awaited stage plus look-ahead over all later stages.
    always_comb begin
        w_code_cur = '0;
        w_eq_later = 1'b0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (s == int'(r_stage)) begin
                w_code_cur = codes_i[s*WIDTH +: WIDTH];
            end
            if ((s > int'(r_stage)) && (check_i == codes_i[s*WIDTH +: WIDTH])) begin
                w_eq_later = 1'b1;
            end
        end
    end

    assign w_eq_cur = (check_i == w_code_cur);

`ifdef CHKMON_STABLE_FILTER_EN
    localparam int               RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [RUN_W-1:0] r_run, w_run_cur;
    logic [WIDTH-1:0] r_prev;
    logic             w_run_clear;

    // w_run_cur: consecutive cycles, including this one, that check_i has held its value.
    always_comb begin
        w_run_cur = RUN_W'(1);
        if ((r_run != '0) && (check_i == r_prev)) begin
            w_run_cur = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
        end
    end

    assign w_stable    = (w_run_cur >= RUN_MAX);
    assign w_run_clear = start_i || (r_state != ST_ARMED) || w_match;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || w_run_clear) begin
            r_run <= '0;
        end else begin
            r_run <= w_run_cur;
        end
        if (wb_rst_i) begin
            r_prev <= '0;
        end else begin
            r_prev <= check_i;
        end
    end
`else
    assign w_stable = 1'b1;
`endif

    assign w_match = w_eq_cur && w_stable;
    assign w_early = (STRICT != 0) && w_eq_later && w_stable;

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_tmr_clear = 1'b0;
        w_tmr_inc   = 1'b0;
        if (start_i) begin
            w_state_nxt = ST_ARMED;
            w_stage_nxt = '0;
            w_tmr_clear = 1'b1;
        end else if (r_state == ST_ARMED) begin
            if (w_match) begin
                w_stage_nxt = r_stage + 1'b1;
                w_tmr_clear = 1'b1;
                if (r_stage == LAST_STAGE) begin
                    w_state_nxt = ST_PASS;
                end
            end else if (w_early) begin
                w_state_nxt = ST_FAIL;
            end else if (w_deadline) begin
                w_state_nxt = ST_TIMEOUT;
            end else begin
                w_tmr_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
        end
    end

    chkmon_stage_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_clear   (w_tmr_clear),
        .i_inc     (w_tmr_inc),
        .i_timeout (timeout_i),
        .o_count   (w_cycles),
        .o_deadline(w_deadline)
    );

    assign busy_o    = (r_state == ST_ARMED);
    assign pass_o    = (r_state == ST_PASS);
    assign fail_o    = (r_state == ST_FAIL);
    assign timeout_o = (r_state == ST_TIMEOUT);
    assign stage_o   = r_stage;
    assign cycles_o  = w_cycles;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// tb/tb_checkpoint_seq_monitor.sv - self-checking bench for checkpoint_seq_monitor (STRICT=1 and STRICT=0)
module tb_checkpoint_seq_monitor;

    localparam int W  = 16;
    localparam int N  = 2;
    localparam int CW = 24;
    localparam int SC = 2;
`ifdef CHKMON_STABLE_FILTER_EN
    localparam int HOLD = SC;
`else
    localparam int HOLD = 1;
`endif
    localparam logic [15:0] C_FEED = 16'hFEED;
    localparam logic [15:0] C_DEAD = 16'hDEAD;
    localparam int M_IDLE = 0, M_ARMED = 1, M_PASS = 2, M_FAIL = 3, M_TMO = 4;
    localparam longint CYC_MAX = (64'd1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  chk   = '0;
    logic [N*W-1:0] codes = {C_DEAD, C_FEED};
    logic [CW-1:0] tmo   = 24'd100;

    logic          busy [2];
    logic          pass [2];
    logic          fail [2];
    logic          tmo_o[2];
    logic [1:0]    stg  [2];
    logic [CW-1:0] cyc  [2];

    int errors = 0;
    int checks = 0;

    int            m_state[2];
    int            m_stage[2];
    longint        m_cyc  [2];
    logic [W-1:0]  m_hist [2][$];

    always #5 clk = ~clk;

    checkpoint_seq_monitor #(.WIDTH(W), .NUM_STAGES(N), .CNT_W(CW), .STRICT(1), .STABLE_CYCLES(SC)) u_strict (
        .wb_clk_i(clk), .wb_rst_i(rst), .check_i(chk), .codes_i(codes), .timeout_i(tmo), .start_i(start),
        .busy_o(busy[0]), .pass_o(pass[0]), .fail_o(fail[0]), .timeout_o(tmo_o[0]), .stage_o(stg[0]), .cycles_o(cyc[0]));

    checkpoint_seq_monitor #(.WIDTH(W), .NUM_STAGES(N), .CNT_W(CW), .STRICT(0), .STABLE_CYCLES(SC)) u_loose (
        .wb_clk_i(clk), .wb_rst_i(rst), .check_i(chk), .codes_i(codes), .timeout_i(tmo), .start_i(start),
        .busy_o(busy[1]), .pass_o(pass[1]), .fail_o(fail[1]), .timeout_o(tmo_o[1]), .stage_o(stg[1]), .cycles_o(cyc[1]));

    // Reference: instance 0 is STRICT, instance 1 ignores early codes.
    task automatic model_step(input logic r, input logic s, input logic [W-1:0] c);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_state[i] = M_IDLE; m_stage[i] = 0; m_cyc[i] = 0; m_hist[i].delete();
            end else if (s) begin
                m_state[i] = M_ARMED; m_stage[i] = 0; m_cyc[i] = 0; m_hist[i].delete();
            end else if (m_state[i] == M_ARMED) begin
                bit stab, early;
                logic [W-1:0] want;
                m_hist[i].push_back(c);
                stab = (m_hist[i].size() >= HOLD);
                for (int k = 0; k < HOLD && stab; k++)
                    if (m_hist[i][m_hist[i].size()-1-k] != c) stab = 0;
                want  = codes[m_stage[i]*W +: W];
                early = 0;
                for (int j = m_stage[i] + 1; j < N; j++)
                    if (codes[j*W +: W] == c) early = 1;
                if (stab && c == want) begin
                    m_stage[i]++; m_cyc[i] = 0; m_hist[i].delete();
                    if (m_stage[i] == N) m_state[i] = M_PASS;
                end else if (i == 0 && early && stab) begin
                    m_state[i] = M_FAIL;
                end else if (tmo != 0 && m_cyc[i] == longint'(tmo) - 1) begin
                    m_state[i] = M_TMO;
                end else if (m_cyc[i] < CYC_MAX) begin
                    m_cyc[i]++;
                end
            end
        end
    endtask

    function automatic logic [29:0] dut_vec(input int i);
        return {busy[i], pass[i], fail[i], tmo_o[i], stg[i], cyc[i]};
    endfunction

    function automatic logic [29:0] exp_vec(input int i);
        return {m_state[i] == M_ARMED, m_state[i] == M_PASS, m_state[i] == M_FAIL,
                m_state[i] == M_TMO, 2'(m_stage[i]), 24'(m_cyc[i])};
    endfunction

    task automatic drive(input logic [W-1:0] c, input logic s, input logic r);
        @(negedge clk);
        chk = c; start = s; rst = r;
        @(posedge clk);
        model_step(r, s, c);
        #1;
    endtask

    task automatic hold_code(input logic [W-1:0] c);
        repeat (HOLD) drive(c, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec(i) !== 30'd0) begin
                errors++; $display("FAIL reset inst%0d got=%h want=%h", i, dut_vec(i), 30'd0);
            end
        end
        drive('0, 1'b0, 1'b0);
        checks++;
        if (dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL reset_release got=%h want=%h", dut_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_pass();
        drive('0, 1'b1, 1'b0);
        repeat (4) drive('0, 1'b0, 1'b0);
        hold_code(C_FEED);
        checks++;
        if (stg[0] !== 2'd1 || cyc[0] !== 24'd0) begin
            errors++; $display("FAIL pass_feed stage=%0d cycles=%0d want stage=1 cycles=0", stg[0], cyc[0]);
        end
        repeat (14) drive('0, 1'b0, 1'b0);
        checks++;
        if (dut_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL pass_mid got=%h want=%h", dut_vec(0), exp_vec(0));
        end
        hold_code(C_DEAD);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec(i) !== {4'b0100, 2'd2, 24'd0}) begin
                errors++; $display("FAIL pass_done inst%0d got=%h want=%h", i, dut_vec(i), {4'b0100, 2'd2, 24'd0});
            end
        end
    endtask

    task automatic test_timeout();
        drive('0, 1'b1, 1'b0);
        hold_code(C_FEED);
        repeat (99) drive('0, 1'b0, 1'b0);
        checks++;
        if (dut_vec(0) !== {4'b1000, 2'd1, 24'd99}) begin
            errors++; $display("FAIL tmo_before got=%h want=%h", dut_vec(0), {4'b1000, 2'd1, 24'd99});
        end
        drive('0, 1'b0, 1'b0);
        checks++;
        if (dut_vec(0) !== {4'b0001, 2'd1, 24'd99}) begin
            errors++; $display("FAIL tmo_hit got=%h want=%h", dut_vec(0), {4'b0001, 2'd1, 24'd99});
        end
        repeat (3) drive(C_DEAD, 1'b0, 1'b0);
        checks++;
        if (dut_vec(1) !== {4'b0001, 2'd1, 24'd99}) begin
            errors++; $display("FAIL tmo_hold got=%h want=%h", dut_vec(1), {4'b0001, 2'd1, 24'd99});
        end
    endtask

    task automatic test_strict();
        drive('0, 1'b1, 1'b0);
        hold_code(C_DEAD);
        checks++;
        if (dut_vec(0) !== {4'b0010, 2'd0, 24'(HOLD - 1)}) begin
            errors++; $display("FAIL strict_fail got=%h want=%h", dut_vec(0), {4'b0010, 2'd0, 24'(HOLD - 1)});
        end
        checks++;
        if (busy[1] !== 1'b1 || fail[1] !== 1'b0 || stg[1] !== 2'd0) begin
            errors++; $display("FAIL loose_ignore busy=%0b fail=%0b stage=%0d want 1 0 0", busy[1], fail[1], stg[1]);
        end
        drive('0, 1'b0, 1'b0);
        hold_code(C_FEED);
        drive('0, 1'b0, 1'b0);
        hold_code(C_DEAD);
        checks++;
        if (pass[1] !== 1'b1 || stg[1] !== 2'd2) begin
            errors++; $display("FAIL loose_pass pass=%0b stage=%0d want 1 2", pass[1], stg[1]);
        end
        checks++;
        if (fail[0] !== 1'b1 || pass[0] !== 1'b0 || stg[0] !== 2'd0) begin
            errors++; $display("FAIL strict_sticky fail=%0b pass=%0b stage=%0d want 1 0 0", fail[0], pass[0], stg[0]);
        end
    endtask

    task automatic test_deadline();
        drive('0, 1'b1, 1'b0);
        hold_code(C_FEED);
        repeat (100 - HOLD) drive('0, 1'b0, 1'b0);
        hold_code(C_DEAD);
        checks++;
        if (pass[0] !== 1'b1 || tmo_o[0] !== 1'b0 || stg[0] !== 2'd2) begin
            errors++; $display("FAIL deadline_match pass=%0b timeout=%0b stage=%0d want 1 0 2", pass[0], tmo_o[0], stg[0]);
        end
        tmo = '0;
        drive('0, 1'b1, 1'b0);
        repeat (10000) drive('0, 1'b0, 1'b0);
        checks++;
        if (dut_vec(0) !== {4'b1000, 2'd0, 24'd10000}) begin
            errors++; $display("FAIL no_timeout got=%h want=%h", dut_vec(0), {4'b1000, 2'd0, 24'd10000});
        end
        tmo = 24'd100;
    endtask

    task automatic test_reset_restart();
        drive('0, 1'b1, 1'b0);
        hold_code(C_FEED);
        drive('0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec(i) !== 30'd0) begin
                errors++; $display("FAIL mid_reset inst%0d got=%h want=%h", i, dut_vec(i), 30'd0);
            end
        end
        drive('0, 1'b0, 1'b0);
        drive('0, 1'b1, 1'b0);
        hold_code(C_FEED);
        hold_code(C_DEAD);
        drive('0, 1'b1, 1'b0);
        checks++;
        if (dut_vec(0) !== {4'b1000, 2'd0, 24'd0}) begin
            errors++; $display("FAIL restart_from_pass got=%h want=%h", dut_vec(0), {4'b1000, 2'd0, 24'd0});
        end
    endtask

`ifdef CHKMON_STABLE_FILTER_EN
    task automatic test_filter();
        drive('0, 1'b1, 1'b0);
        drive(C_FEED, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        checks++;
        if (stg[0] !== 2'd0) begin
            errors++; $display("FAIL filter_glitch stage=%0d want=0", stg[0]);
        end
        drive(C_FEED, 1'b0, 1'b0);
        drive(C_FEED, 1'b0, 1'b0);
        checks++;
        if (stg[0] !== 2'd1) begin
            errors++; $display("FAIL filter_hold stage=%0d want=1", stg[0]);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] c;
        logic s, r;
        c = '0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 599) == 0);
            s = ($urandom_range(0, 39) == 0);
            if (s) tmo = ($urandom_range(0, 3) == 0) ? '0 : 24'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0: c = C_FEED;
                    1: c = C_DEAD;
                    2: c = '0;
                    default: c = 16'($urandom);
                endcase
            end
            drive(c, s, r);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL random n=%0d inst%0d got=%h want=%h", n, i, dut_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_state[i] = M_IDLE; m_stage[i] = 0; m_cyc[i] = 0;
        end
        test_reset();
        test_pass();
        test_timeout();
        test_strict();
        test_deadline();
        test_reset_restart();
`ifdef CHKMON_STABLE_FILTER_EN
        test_filter();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
